pipeline_stage_reg: RTL
=======================

# pipeline_stage_reg

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and a stall-cycle counter. It replaces fixed enable/clear stage registers such as IF/ID, ID/EX, EX/MEM and MEM/WB in the pipelined RV32I core. Any stage payload is carried as one flat vector. An optional skid entry registers the backpressure path, so upstream ready no longer depends combinationally on downstream ready.

## Interface
Parameters:
- DATA_W, default 96: payload width in bits (e.g. instr + PC + PC+4 at `XLEN=32`).
- CNT_W, default 16: stall counter width.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous flush; discards all held and incoming beats.
- i_valid  in  1  upstream beat valid.
- i_data  in  DATA_W  upstream payload.
- o_ready  out  1  stage can accept a beat this cycle.
- o_valid  out  1  output beat valid.
- o_data  out  DATA_W  output payload, registered.
- i_ready  in  1  downstream accepts the beat.
- o_stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- Handshakes:
  - Upstream handshake occurs when i_valid && o_ready.
  - Downstream handshake occurs when o_valid && i_ready.
- Storage is one main register (o_data/o_valid). With PIPE_SKID_EN, a skid register (skid_data/skid_valid) is added.
- States without skid:
  - EMPTY (o_valid=0) moves to FULL on an upstream handshake.
  - FULL stays FULL on a simultaneous push and pop (new data loaded).
  - FULL moves to EMPTY on a pop without a push.
  - FULL holds data and valid when i_ready=0.
- States with skid:
  - EMPTY moves to ONE on a push.
  - ONE stays ONE on a push and pop.
  - ONE moves to EMPTY on a pop with no push.
  - ONE moves to TWO on a push with no pop; the beat goes to skid.
  - TWO moves to ONE on a pop; skid moves to main and skid_valid clears.
  - No push is possible in TWO.
- Beats leave in strict arrival order. No beat is duplicated or dropped except by flush.
- Flush has priority over every other event in the cycle:
  - all valid bits clear and all data registers load 0;
  - any upstream handshake in the same cycle is discarded;
  - the state returns to EMPTY next cycle.
- Stall counter:
  - increments each cycle o_valid && !i_ready;
  - saturates at 2^CNT_W-1;
  - is unaffected by flush and cleared only by reset.
- o_data is a don't-care-free value: it holds its last loaded value, or 0 after reset or flush, while o_valid=0.

## Timing
- Reset values:
  - o_valid=0, o_data=0, o_stall_cnt=0, skid_valid=0, skid_data=0.
  - o_ready=1 in both configurations.
- Latency is 1 cycle: a beat accepted at edge N appears on o_data/o_valid after edge N.
- Throughput is 1 beat/cycle under continuous i_ready=1.
- No-skid o_ready is combinational: o_ready = !o_valid || i_ready.
- Skid o_ready is registered: o_ready = !skid_valid.
  - It falls the cycle after entering TWO.
  - It rises the cycle after the TWO to ONE pop.
- A reset asserted mid-transfer clears state immediately, asynchronously. Partially transferred beats are lost.
- Flush in the same cycle as a pop: the downstream consumer sees the pop as taken, and the stage is EMPTY next cycle.

## Configuration
- Macro: PIPE_SKID_EN.
- Defined:
  - the skid register is instantiated;
  - o_ready is registered;
  - the stage absorbs one extra beat on a downstream stall with no combinational i_ready-to-o_ready path.
- Undefined:
  - no skid storage;
  - o_ready = !o_valid || i_ready;
  - behaviour is otherwise identical, and state TWO is unreachable.

## Test plan
- Reset check: hold i_rstn=0, then release. Required: o_valid=0, o_data=0, o_stall_cnt=0, o_ready=1.
- Streaming: beats 0x1, 0x2, 0x3 on consecutive cycles with i_ready=1. Required: o_data shows 0x1, 0x2, 0x3 one cycle later on consecutive cycles, o_valid=1 throughout.
- Stall, no skid: beat 0xA accepted, then i_ready=0 for 3 cycles while i_valid=1 with 0xB. Required: o_data holds 0xA, o_ready=0, o_stall_cnt=3; after i_ready=1, 0xB follows.
- Stall, skid: same stimulus. Required: 0xB captured in skid, o_ready drops the next cycle; on release, output order is 0xA then 0xB with no gap.
- Flush: in state FULL or TWO, assert i_flush with i_valid=1 and data 0xC. Required next cycle: o_valid=0, o_data=0, 0xC never appears, o_stall_cnt unchanged.
- Saturation: with CNT_W=4, stall for 20 cycles. Required: o_stall_cnt=15 and holding.

Source files
------------

// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: one pipeline stage holding a flat payload, with a
// valid/ready handshake on both sides, a synchronous flush and a saturating
// count of downstream stall cycles.
//
// Build option: define PIPE_SKID_EN to add a skid entry. The upstream ready
// then comes from a register instead of from the downstream ready.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_EMPTY | nothing held, o_valid=0
// ST_ONE   | main register holds a beat, o_valid=1
// ST_TWO   | main and skid both hold a beat (only with PIPE_SKID_EN)

module pipeline_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_valid;
`endif

    // State register; reset clears the stage immediately.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush wins over every handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) state_d = ST_ONE;
                end
                ST_ONE: begin
                    if (push && !pop) begin
`ifdef PIPE_SKID_EN
                        state_d = ST_TWO;
`else
                        state_d = ST_ONE;
`endif
                    end else if (!push && pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) state_d = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Outputs and handshake qualifiers, all derived from registered state.
    always_comb begin
        o_valid     = (state_q != ST_EMPTY);
        o_data      = data_q;
        o_stall_cnt = cnt_q;
`ifdef PIPE_SKID_EN
        skid_valid  = (state_q == ST_TWO);
        o_ready     = !skid_valid;
`else
        // Without a skid entry a held beat can only be replaced while it leaves.
        o_ready     = !o_valid || i_ready;
`endif
        push        = i_valid && o_ready;
        pop         = o_valid && i_ready;
    end

    // Payload steering: new beats go to main when it frees up, else to skid.
    always_comb begin
        data_d      = data_q;
`ifdef PIPE_SKID_EN
        skid_data_d = skid_data_q;
`endif
        if (i_flush) begin
            data_d      = '0;
`ifdef PIPE_SKID_EN
            skid_data_d = '0;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) data_d = i_data;
                end
                ST_ONE: begin
                    if (push && pop) begin
                        data_d = i_data;
`ifdef PIPE_SKID_EN
                    end else if (push) begin
                        skid_data_d = i_data;
`endif
                    end
                end
                ST_TWO: begin
`ifdef PIPE_SKID_EN
                    if (pop) data_d = skid_data_q;
`endif
                end
                default: data_d = data_q;
            endcase
        end
    end

    // Payload registers; zero after reset so o_data is never undefined.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            data_q      <= '0;
`ifdef PIPE_SKID_EN
            skid_data_q <= '0;
`endif
        end else begin
            data_q      <= data_d;
`ifdef PIPE_SKID_EN
            skid_data_q <= skid_data_d;
`endif
        end
    end

    // Stall count: a held beat refused downstream; flush does not clear it.
    always_comb begin
        cnt_d = cnt_q;
        if (o_valid && !i_ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
